stack_seq: RTL
==============

# stack_seq

Push/pull sequencer for PSHS/PSHU/PULS/PULU (and interrupt-frame stacking). Sits beside the register block and drives its `path_left_addr`, `dec_su`/`inc_su`, `use_s` and `write_reg` controls. It walks the postbyte register mask and moves one byte per memory transaction between the register file and the stack, using the register block's `reg_su` as the address.

## Interface
Parameters: none.

Ports:
- `clk_in` in 1: clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: begin an operation; sampled only in IDLE.
- `is_pull` in 1: 1 = pull, 0 = push.
- `use_s` out 1: stack select to the register block, latched at start from `sel_s`.
- `sel_s` in 1: 1 = S stack, 0 = U stack.
- `postbyte` in 8: register mask, latched at start.
  - Bit 7 PC, bit 6 the other stack pointer (U if `sel_s`, else S), bit 5 Y, bit 4 X.
  - Bit 3 DP, bit 2 B, bit 1 A, bit 0 CC.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.
- `reg_su` in 16: selected stack pointer from the register block.
- `path_left_addr` out 4: `RN_*` code of the register being pushed.
- `path_left_data` in 16: its value.
- `ccr_in` in 8: current CCR, used for pushing CC.
- `dec_su` out 1: decrement the selected stack pointer.
- `inc_su` out 1: increment the selected stack pointer.
- `write_reg` out 1: register write strobe.
- `write_reg_addr` out 4: register write code. 0 D, 1 X, 2 Y, 3 U, 4 S, 5 PC, 8 A, 9 B, 10 CC, 11 DP.
- `data_w` out 16: write data.
- `mem_addr` out 16: equals `reg_su`, combinational.
- `mem_dout` out 8: byte to write.
- `mem_din` in 8: read data, valid when `mem_ready`=1.
- `mem_we` out 1: write strobe.
- `mem_rd` out 1: read strobe.
- `mem_ready` in 1: completes the current memory transaction.

## Operation
- States: IDLE, DEC, WRITE, READ, INC, DONE.
- Working registers:
  - `mask`: remaining bits.
  - `hi`: selects the byte half of 16-bit registers.
  - `lo_byte`: pulled low byte of a 16-bit register.
- IDLE: when `start`=1, latch `postbyte`, `is_pull` and `sel_s`, and set `hi`=0.
  - Next state is DONE if `postbyte`=0.
  - Otherwise next state is DEC (push) or READ (pull).
- Push order is highest set bit first: PC, other SP, Y, X, DP, B, A, CC.
  - A 16-bit register is pushed low byte then high byte.
- DEC: `dec_su`=1 for one cycle, then go to WRITE.
- WRITE: `mem_we`=1 and `mem_dout` = the selected byte; hold until `mem_ready`=1.
  - 16-bit register: low byte on the first pass, high byte on the second. `hi` toggles after each byte.
  - When a register completes, clear its mask bit. Then go to DEC if mask is nonzero, else DONE.
  - CC byte = `ccr_in`. DP, A and B use `path_left_data[7:0]`.
- Pull order is lowest set bit first: CC, A, B, DP, X, Y, other SP, PC.
  - A 16-bit register is pulled high byte then low byte.
- READ: `mem_rd`=1; hold until `mem_ready`=1, then latch `mem_din` and go to INC.
- INC: `inc_su`=1 for one cycle.
  - 8-bit register: `write_reg`=1 with `data_w`={8'h00, byte} in this cycle.
  - 16-bit register, first byte: latch it and toggle `hi`.
  - 16-bit register, second byte: `write_reg`=1 with `data_w`={high, low}.
  - Then go to READ if mask is nonzero, else DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Other-SP write code is 3 (U) when `sel_s`=1, else 4 (S). The selected stack pointer is never written by `write_reg`.
- `start` while `busy`=1 is ignored.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `mem_we` 0, `mem_rd` 0, `dec_su` 0, `inc_su` 0, `write_reg` 0, mask 0, `use_s` 1.
- `busy`=1 in every state other than IDLE.
- `dec_su`/`inc_su` take effect at the closing edge. WRITE and READ therefore address the already-decremented, or not-yet-incremented, pointer.
- With `mem_ready` tied to 1, each byte takes 2 cycles. Total busy cycles = 2·bytes + 1.
- Each stall cycle (`mem_ready`=0) adds one cycle; strobes and address stay stable during a stall.
- Reset mid-operation: return to IDLE immediately with all strobes low. Stack pointer changes already made are not undone.

## Test plan
- Push: S=0x0F00, mask 0xFF, `mem_ready`=1.
  - Expect 12 writes, busy 25 cycles, final S=0x0EF4.
  - Expect memory 0x0EF4..0x0EFF = CC, A, B, DP, Xh, Xl, Yh, Yl, Uh, Ul, PCh, PCl.
- Pull: U=0x0E00 holding bytes 0x11, 0x22, mask 0x06.
  - Expect A=0x11, B=0x22, U=0x0E02, `done` on cycle 5.
- Pull: mask 0x10 with bytes 0x12, 0x34.
  - Expect a single `write_reg` code 1 with `data_w`=0x1234.
- Empty mask: busy for 1 cycle with `done`, and no strobes.
- Stall: `mem_ready` low for 3 cycles during the first byte of a push of A.
  - Expect `mem_we` and `mem_addr` held; total busy 6 cycles.
- Reset asserted during READ: all outputs at reset values the same cycle.
  - A later `start` runs normally; `start` pulsed while busy is ignored.

Source files
------------

// File: rtl/stack_seq_if.sv
// stack_seq_if
//   Byte-wide memory bus used by the push/pull sequencer to reach the stack.
//
//   mem_addr  : byte address (the selected stack pointer)
//   mem_dout  : byte to write
//   mem_din   : byte read back, valid while mem_ready=1
//   mem_we    : write strobe
//   mem_rd    : read strobe
//   mem_ready : completes the current transaction
//
//   master = the sequencer, slave = the memory.
interface stack_seq_if;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic        mem_rd;
  logic        mem_ready;

  modport master (
    output mem_addr,
    output mem_dout,
    output mem_we,
    output mem_rd,
    input  mem_din,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_dout,
    input  mem_we,
    input  mem_rd,
    output mem_din,
    output mem_ready
  );
endinterface

// File: rtl/stack_seq.sv
// stack_seq
//   Push/pull sequencer for PSHS/PSHU/PULS/PULU and interrupt-frame stacking.
//   Walks the postbyte register mask and moves one byte per memory
//   transaction between the register block and the stack, using the register
//   block's selected stack pointer (reg_su) as the address.
//
//   Ports
//     clk_in, reset          : clock, asynchronous active-high reset
//     start, is_pull         : begin an operation (IDLE only); 1 = pull, 0 = push
//     sel_s, use_s           : stack select in (1 = S); latched copy out to the register block
//     postbyte               : register mask (7 PC, 6 other SP, 5 Y, 4 X, 3 DP, 2 B, 1 A, 0 CC)
//     busy, done             : operation in progress; one-cycle completion pulse
//     reg_su                 : selected stack pointer value
//     path_left_addr/_data   : register code being pushed and its value
//     ccr_in                 : current CCR, pushed for the CC bit
//     dec_su, inc_su         : adjust the selected stack pointer at the closing edge
//     write_reg, write_reg_addr, data_w : register write port for pulled values
//     mem                    : byte memory bus (stack_seq_if master)
module stack_seq (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        start,
  input  logic        is_pull,
  input  logic        sel_s,
  input  logic [7:0]  postbyte,
  output logic        use_s,
  output logic        busy,
  output logic        done,
  input  logic [15:0] reg_su,
  output logic [3:0]  path_left_addr,
  input  logic [15:0] path_left_data,
  input  logic [7:0]  ccr_in,
  output logic        dec_su,
  output logic        inc_su,
  output logic        write_reg,
  output logic [3:0]  write_reg_addr,
  output logic [15:0] data_w,
  stack_seq_if.master mem
);

  // Register block codes
  localparam logic [3:0] RN_X  = 4'd1;
  localparam logic [3:0] RN_Y  = 4'd2;
  localparam logic [3:0] RN_U  = 4'd3;
  localparam logic [3:0] RN_S  = 4'd4;
  localparam logic [3:0] RN_PC = 4'd5;
  localparam logic [3:0] RN_A  = 4'd8;
  localparam logic [3:0] RN_B  = 4'd9;
  localparam logic [3:0] RN_CC = 4'd10;
  localparam logic [3:0] RN_DP = 4'd11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEC   = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    INC   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  mask, mask_nxt;
  logic        pull_q, pull_nxt;
  logic        sel_q, sel_nxt;
  logic        hi, hi_nxt;
  logic [7:0]  lo_byte, lo_byte_nxt;
  logic [7:0]  hi_byte, hi_byte_nxt;

  logic [2:0]  cur_idx;
  logic        cur_wide;
  logic [3:0]  cur_code;
  logic [7:0]  mask_cleared;
  logic [7:0]  push_byte;

  // Register currently being moved: pushes take the highest set bit,
  // pulls the lowest, so the loop direction picks the winner.
  always_comb begin
    cur_idx = 3'd0;
    if (pull_q) begin
      for (int i = 7; i >= 0; i--)
        if (mask[i]) cur_idx = 3'(i);
    end else begin
      for (int i = 0; i < 8; i++)
        if (mask[i]) cur_idx = 3'(i);
    end
  end

  // Bits 4..7 are the 16-bit registers.
  assign cur_wide     = cur_idx[2];
  assign mask_cleared = mask & ~(8'd1 << cur_idx);

  // Bit 6 is always the stack that is not being used for the transfer.
  always_comb begin
    cur_code = RN_CC;
    case (cur_idx)
      3'd7:    cur_code = RN_PC;
      3'd6:    cur_code = sel_q ? RN_U : RN_S;
      3'd5:    cur_code = RN_Y;
      3'd4:    cur_code = RN_X;
      3'd3:    cur_code = RN_DP;
      3'd2:    cur_code = RN_B;
      3'd1:    cur_code = RN_A;
      default: cur_code = RN_CC;
    endcase
  end

  // CC comes from the live CCR rather than the register path; 16-bit
  // registers go out low byte first (hi=0) then high byte.
  always_comb begin
    if (cur_idx == 3'd0)
      push_byte = ccr_in;
    else if (cur_wide && hi)
      push_byte = path_left_data[15:8];
    else
      push_byte = path_left_data[7:0];
  end

  assign path_left_addr = cur_code;
  assign write_reg_addr = cur_code;
  assign mem.mem_addr   = reg_su;
  assign mem.mem_dout   = (state == WRITE) ? push_byte : 8'h00;
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign use_s          = sel_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mask    <= 8'h00;
      pull_q  <= 1'b0;
      sel_q   <= 1'b1;
      hi      <= 1'b0;
      lo_byte <= 8'h00;
      hi_byte <= 8'h00;
    end else begin
      state   <= state_nxt;
      mask    <= mask_nxt;
      pull_q  <= pull_nxt;
      sel_q   <= sel_nxt;
      hi      <= hi_nxt;
      lo_byte <= lo_byte_nxt;
      hi_byte <= hi_byte_nxt;
    end
  end

  // Next-state and strobe logic. Stack pointer adjustments land at the end
  // of DEC/INC, so WRITE sees the decremented pointer and READ the pointer
  // before its increment.
  always_comb begin
    state_nxt   = state;
    mask_nxt    = mask;
    pull_nxt    = pull_q;
    sel_nxt     = sel_q;
    hi_nxt      = hi;
    lo_byte_nxt = lo_byte;
    hi_byte_nxt = hi_byte;
    dec_su      = 1'b0;
    inc_su      = 1'b0;
    write_reg   = 1'b0;
    data_w      = 16'h0000;
    mem.mem_we  = 1'b0;
    mem.mem_rd  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          mask_nxt = postbyte;
          pull_nxt = is_pull;
          sel_nxt  = sel_s;
          hi_nxt   = 1'b0;
          if (postbyte == 8'h00)
            state_nxt = DONE;
          else if (is_pull)
            state_nxt = READ;
          else
            state_nxt = DEC;
        end
      end

      DEC: begin
        dec_su    = 1'b1;
        state_nxt = WRITE;
      end

      WRITE: begin
        mem.mem_we = 1'b1;
        if (mem.mem_ready) begin
          if (cur_wide && !hi) begin
            hi_nxt    = 1'b1;
            state_nxt = DEC;
          end else begin
            hi_nxt    = 1'b0;
            mask_nxt  = mask_cleared;
            state_nxt = (mask_cleared != 8'h00) ? DEC : DONE;
          end
        end
      end

      READ: begin
        mem.mem_rd = 1'b1;
        if (mem.mem_ready) begin
          lo_byte_nxt = mem.mem_din;
          state_nxt   = INC;
        end
      end

      INC: begin
        inc_su = 1'b1;
        if (cur_wide && !hi) begin
          // First pulled byte of a 16-bit register is its high half.
          hi_byte_nxt = lo_byte;
          hi_nxt      = 1'b1;
          state_nxt   = READ;
        end else begin
          write_reg = 1'b1;
          data_w    = cur_wide ? {hi_byte, lo_byte} : {8'h00, lo_byte};
          hi_nxt    = 1'b0;
          mask_nxt  = mask_cleared;
          state_nxt = (mask_cleared != 8'h00) ? READ : DONE;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
